// File: rtl/rotor_checker.sv
// rtl/rotor_checker.sv - shadow-model checker for the rotor sequence generator's A register
// Optional forbidden-value check enabled by defining ROTOR_CHECKER_FORBID_EN.
module rotor_checker #(
  parameter int WIDTH  = 5,
  parameter int A_INIT = 1,
  parameter int B_INIT = 5,
  parameter int C_INIT = 7,
  parameter int T_INIT = 11,
  parameter int T_STEP = 2,
  parameter int FORBID = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             match,
  output logic             fail,
  output logic             prop,
  output logic [1:0]       err_code,
  output logic [15:0]      sample_cnt
);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_FAIL  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_FIRST    = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_FORBID   = 2'd3;

  localparam logic [WIDTH-1:0] A0     = WIDTH'(A_INIT);
  localparam logic [WIDTH-1:0] B0     = WIDTH'(B_INIT);
  localparam logic [WIDTH-1:0] C0     = WIDTH'(C_INIT);
  localparam logic [WIDTH-1:0] T0     = WIDTH'(T_INIT);
  localparam logic [WIDTH-1:0] TSTEP  = WIDTH'(T_STEP);
  localparam logic [WIDTH-1:0] FVAL   = WIDTH'(FORBID);
  localparam logic [WIDTH-1:0] K1     = WIDTH'(1);
  localparam logic [WIDTH-1:0] K3     = WIDTH'(3);
  localparam logic [WIDTH-1:0] K5     = WIDTH'(5);
  localparam logic [WIDTH-1:0] K7     = WIDTH'(7);

`ifdef ROTOR_CHECKER_FORBID_EN
  localparam bit FORBID_EN = 1'b1;
`else
  localparam bit FORBID_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sc_q, sc_d, st_q, st_d;
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;

  logic             accept;
  logic             forbid_hit;
  logic [WIDTH-1:0] adv_a;

  assign in_ready   = (state_q != S_FAIL);
  assign accept     = in_valid && in_ready;
  assign forbid_hit = FORBID_EN && (in_data == FVAL);

  // Next generator A value, from the pre-update shadow registers.
  always_comb begin
    adv_a = st_q;
    if (sb_q == K5)      adv_a = K5;
    else if (sc_q == K1) adv_a = K7;
    else if (sb_q == K1) adv_a = K3;
  end

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    sc_d         = sc_q;
    st_d         = st_q;
    match_d      = 1'b0;
    fail_d       = fail_q;
    err_code_d   = err_code_q;
    sample_cnt_d = sample_cnt_q;

    if (accept) begin
      if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;

      if (forbid_hit) begin
        state_d    = S_FAIL;
        fail_d     = 1'b1;
        err_code_d = ERR_FORBID;
      end else begin
        case (state_q)
          S_SYNC: begin
            if (in_data == A0) begin
              match_d = 1'b1;
              sa_d    = adv_a;
              sb_d    = sc_q;
              sc_d    = sa_q;
              st_d    = st_q + TSTEP;
              state_d = S_TRACK;
            end else begin
              state_d    = S_FAIL;
              fail_d     = 1'b1;
              err_code_d = ERR_FIRST;
            end
          end
          S_TRACK: begin
            if (in_data == sa_q) begin
              match_d = 1'b1;
              sa_d    = adv_a;
              sb_d    = sc_q;
              sc_d    = sa_q;
              st_d    = st_q + TSTEP;
            end else begin
              state_d    = S_FAIL;
              fail_d     = 1'b1;
              err_code_d = ERR_MISMATCH;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_SYNC;
      sa_q         <= A0;
      sb_q         <= B0;
      sc_q         <= C0;
      st_q         <= T0;
      match_q      <= 1'b0;
      fail_q       <= 1'b0;
      err_code_q   <= ERR_NONE;
      sample_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      sc_q         <= sc_d;
      st_q         <= st_d;
      match_q      <= match_d;
      fail_q       <= fail_d;
      err_code_q   <= err_code_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign match      = match_q;
  assign fail       = fail_q;
  assign prop       = ~fail_q;
  assign err_code   = err_code_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_rotor_checker.sv
// tb/tb_rotor_checker.sv - scoreboard bench for rotor_checker against a generator reference model
module tb_rotor_checker;

  localparam int W = 5;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, match, fail, prop;
  logic [1:0]   err_code;
  logic [15:0]  sample_cnt;

  always #5 clock = ~clock;

  rotor_checker #(.WIDTH(W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .match      (match),
    .fail       (fail),
    .prop       (prop),
    .err_code   (err_code),
    .sample_cnt (sample_cnt)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit m;
    bit f;
    int e;
    int cnt;
  } exp_t;
  exp_t sbq[$];

  // Reference: the generator itself plus the checker's verdict bookkeeping.
  int gen_a, gen_b, gen_c, gen_t;
  bit m_synced, m_failed;
  int m_err, m_cnt;

  function automatic void model_reset();
    gen_a = 1; gen_b = 5; gen_c = 7; gen_t = 11;
    m_synced = 0; m_failed = 0; m_err = 0; m_cnt = 0;
  endfunction

  function automatic void gen_step();
    int na;
    if (gen_b == 5)      na = 5;
    else if (gen_c == 1) na = 7;
    else if (gen_b == 1) na = 3;
    else                 na = gen_t;
    gen_b = gen_c;
    gen_c = gen_a;
    gen_a = na;
    gen_t = (gen_t + 2) % 32;
  endfunction

  task automatic pre_checks();
    chk("in_ready", in_ready, !m_failed);
    chk("prop", prop, !m_failed);
  endtask

  task automatic send(input int x);
    exp_t e;
    bit   fb;
    @(posedge clock); #1;
    pre_checks();
    resetn   = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(x);
    if (!m_failed) begin
      if (m_cnt < 65535) m_cnt++;
      fb = 0;
`ifdef ROTOR_CHECKER_FORBID_EN
      fb = (x == 2);
`endif
      e.m = 0;
      if (fb) begin
        m_failed = 1; m_err = 3;
      end else if (x != gen_a) begin
        m_failed = 1; m_err = m_synced ? 2 : 1;
      end else begin
        m_synced = 1; e.m = 1; gen_step();
      end
      e.f = m_failed; e.e = m_err; e.cnt = m_cnt;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      pre_checks();
      resetn   = 1'b1;
      in_valid = 1'b0;
      in_data  = W'($urandom_range(0, 31));
    end
  endtask

  task automatic do_reset(input bit with_valid);
    @(posedge clock); #1;
    resetn   = 1'b0;
    in_valid = with_valid;
    in_data  = W'($urandom_range(0, 31));
    model_reset();
  endtask

  // Monitor: handshake seen before an edge implies one scoreboard entry after it.
  bit armed = 0, pend = 0, rst_pend = 0;
  always @(negedge clock) begin
    exp_t e;
    if (armed) begin
      if (rst_pend) begin
        chk("rst_match", match, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_code, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_prop", prop, 1);
      end else if (pend) begin
        if (sbq.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("match", match, e.m);
          chk("fail", fail, e.f);
          chk("err_code", err_code, e.e);
          chk("sample_cnt", sample_cnt, e.cnt);
        end
      end else begin
        chk("idle_match", match, 0);
      end
    end
    armed    = armed | !resetn;
    rst_pend = !resetn;
    pend     = resetn && in_valid && in_ready;
  end

  initial begin
    int r;
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);

    send(1); send(5); send(7); send(3); send(5); send(19); idle(2);

    do_reset(0); send(4); idle(2); send(1); idle(1);

    do_reset(1); send(1); send(5); send(9); send(7); send(3); idle(2);

    do_reset(0); send(1); send(2); idle(2);

    do_reset(0); send(1); idle(3); send(5); idle(3); send(7); idle(1);

    do_reset(0); send(1); send(30); idle(1); do_reset(1); send(1); send(5); idle(1);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       do_reset(1'($urandom_range(0, 1)));
      else if (r < 22) idle($urandom_range(1, 3));
      else if (r < 90) send(gen_a);
      else             send($urandom_range(0, 31));
    end

    idle(3);
    chk("queue_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rotor_checker.md
ROTOR_CHECKER -- requirements
Module: rotor_checker

Interface
REQ-001 Parameter WIDTH, 5, sample width in bits.
REQ-002 Parameters A_INIT, B_INIT, C_INIT, T_INIT, defaults 1, 5, 7, 11, the generator's initial register values.
REQ-003 Parameters T_STEP, default 2, and FORBID, default 2: T increment per step, and the value that must never appear.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  sample present on in_data this cycle.
REQ-007 in_data  input  WIDTH  observed value of the generator's A register.
REQ-008 in_ready  output  1  checker accepts a sample this cycle.
REQ-009 match  output  1  one-cycle pulse when an accepted sample equals the predicted value.
REQ-010 fail  output  1  sticky violation flag.
REQ-011 prop  output  1  equals ~fail; safety property output.
REQ-012 err_code  output  2  cause of failure: 0 none, 1 bad first sample, 2 mismatch, 3 forbidden value.
REQ-013 sample_cnt  output  16  count of accepted samples; saturates at 16'hFFFF.

Function
REQ-014 FSM states SHALL be SYNC, TRACK and FAIL; a sample is accepted on a cycle with in_valid and in_ready.
REQ-015 in_ready SHALL be 1 in SYNC and TRACK, and 0 in FAIL.
REQ-016 Shadow registers sa, sb, sc, st (WIDTH bits each) SHALL model the generator.
REQ-017 In SYNC, an accepted sample equal to A_INIT SHALL pulse match, advance the shadow once and enter TRACK; any other value SHALL enter FAIL with err_code 1.
REQ-018 In TRACK, an accepted sample SHALL be compared to sa: if equal, pulse match and advance the shadow; if not equal, enter FAIL with err_code 2 and leave the shadow unchanged.
REQ-019 Shadow advance SHALL be computed from pre-update values, in priority order for sa: sb==5 gives 5; else sc==1 gives 7; else sb==1 gives 3; else st.
REQ-020 Shadow advance SHALL also set sb to sc, sc to sa, and st to st+T_STEP, truncated mod 2^WIDTH.
REQ-021 Cycles without an accepted sample SHALL leave the shadow, FSM and sample_cnt unchanged.
REQ-022 FAIL SHALL be absorbing until reset; fail and err_code SHALL hold.
REQ-023 sample_cnt SHALL increment on every accepted sample, including the failing one, and saturate.
REQ-024 match, fail and err_code SHALL be registered, with a latency of one cycle after acceptance.
REQ-025 If a sample violates more than one check, err_code SHALL use the priority 3 > 2 > 1.

Reset
REQ-026 resetn low at a rising edge SHALL set: FSM to SYNC; shadow to A_INIT, B_INIT, C_INIT, T_INIT; match 0; fail 0; err_code 0; sample_cnt 0.
REQ-027 Reset SHALL override any simultaneous sample, including when asserted in FAIL or mid-stream; in_valid during reset SHALL be ignored.

Configuration
REQ-028 With ROTOR_CHECKER_FORBID_EN defined, any accepted sample equal to FORBID SHALL enter FAIL with err_code 3 in any accepting state.
REQ-029 Without ROTOR_CHECKER_FORBID_EN, no forbidden-value check SHALL exist, and err_code 3 SHALL never be produced.

Verification
REQ-030 Reset, then feed 1,5,7,3,5,19 back-to-back -> six match pulses, fail=0, prop=1, sample_cnt=6.
REQ-031 Reset, then feed 4 -> next cycle fail=1, err_code=1, in_ready=0, sample_cnt=1.
REQ-032 Feed 1,5,9 -> fail=1 and err_code=2 one cycle after the third sample; later valid samples are ignored and sample_cnt stays 3.
REQ-033 With the macro defined, feed 1 then 2 -> err_code=3; without the macro, the same stimulus -> err_code=2.
REQ-034 Feed 1,5 with idle gaps of 3 cycles, then 7 -> all three match and no shadow advance during the gaps.
REQ-035 Force FAIL, then pulse resetn low for 1 cycle alongside in_valid -> all outputs return to reset values, then the sequence 1,5 matches again.
